// File: rtl/mem_bus_master_pkg.sv
// Shared types for the CPU-to-Avalon memory bus master: FSM states, access sizes and
// the alignment check used to reject a request before any bus cycle starts.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUS_RD = 3'd1,
        BUS_WR = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // True for the illegal size code as well as for misaligned half/word accesses.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Avalon-MM master bundle. A transfer completes on any rising edge where read or write
// is high and waitrequest is low; until then the master holds every master output stable.
interface mem_bus_master_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mem_bus_master_lane_steer.sv
// Little-endian byte-lane steering: store byte enables and replicated write data, plus
// load lane extraction with sign or zero extension. Purely combinational.
module mem_lane_steer
    import mem_bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{lo, 3'b000} +: 8];
    assign half_v = lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sgn & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                be         = lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sgn & half_v[15]}}, half_v};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end
endmodule

// File: rtl/mem_bus_master.sv
// Turns one held CPU load/store request into a single Avalon-MM transfer, stalling the
// CPU until it completes; alignment errors and waitrequest timeouts lock up in ERROR.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       req_address,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic [31:0]       req_rdata,
    output logic              req_done,
    output logic              stall,
    output logic              bus_error,
    mem_bus_master_if.master  bus,
    output state_t            dbg_state
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    state_t       state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]  address_q, writedata_q;
    logic [3:0]   byteenable_q;
    logic         read_q, write_q;
    logic [1:0]   size_q, lo_q;
    logic         sgn_q;

    logic [1:0]   st_size, st_lo;
    logic         st_sgn;
    logic [3:0]   st_be;
    logic [31:0]  st_wdata, st_rdata;

    // One steering instance: request fields while idle, captured fields during the load.
    assign st_size = (state == IDLE) ? req_size           : size_q;
    assign st_lo   = (state == IDLE) ? req_address[1:0]   : lo_q;
    assign st_sgn  = (state == IDLE) ? req_signed         : sgn_q;

    mem_lane_steer u_steer (
        .size       (st_size),
        .lo         (st_lo),
        .sgn        (st_sgn),
        .wdata      (req_wdata),
        .rdata      (bus.readdata),
        .be         (st_be),
        .wdata_lane (st_wdata),
        .rdata_ext  (st_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= '0;
            lo_q         <= '0;
            sgn_q        <= 1'b0;
            req_rdata    <= '0;
            req_done     <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            req_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        if ((req_read && req_write) || misaligned(req_size, req_address[1:0])) begin
                            state     <= ERROR;
                            bus_error <= 1'b1;
                        end else begin
                            address_q    <= {req_address[31:2], 2'b00};
                            byteenable_q <= st_be;
                            writedata_q  <= st_wdata;
                            size_q       <= req_size;
                            lo_q         <= req_address[1:0];
                            sgn_q        <= req_signed;
                            wait_cnt     <= '0;
                            read_q       <= req_read;
                            write_q      <= req_write;
                            state        <= req_read ? BUS_RD : BUS_WR;
                        end
                    end
                end
                BUS_RD, BUS_WR: begin
                    if (!bus.waitrequest) begin
                        read_q   <= 1'b0;
                        write_q  <= 1'b0;
                        req_done <= 1'b1;
                        state    <= DONE;
                        if (state == BUS_RD) req_rdata <= st_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                            read_q    <= 1'b0;
                            write_q   <= 1'b0;
                            bus_error <= 1'b1;
                            state     <= ERROR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = ((state == IDLE) && (req_read || req_write)) ||
                   (state == BUS_RD) || (state == BUS_WR) || (state == ERROR);

    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = byteenable_q;
    assign dbg_state      = state;
endmodule
